// File: rtl/clk_div_checker_if.sv
// Signal bundle for clk_div_checker: the divided clock under test plus all
// measurement/status outputs and a debug view of the checker state.
interface clk_div_checker_if #(
    parameter int CNT_W = 3
);
    logic             div_clk_i;
    logic             edge_o;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             lock_o;
    logic             err_o;
    logic             err_sticky_o;
    logic             stuck_o;
    logic [7:0]       err_cnt_o;
    logic [1:0]       state_o;

    modport slave (
        input  div_clk_i,
        output edge_o, period_o, high_o, lock_o, err_o,
        output err_sticky_o, stuck_o, err_cnt_o, state_o
    );

    modport master (
        output div_clk_i,
        input  edge_o, period_o, high_o, lock_o, err_o,
        input  err_sticky_o, stuck_o, err_cnt_o, state_o
    );
endinterface

// File: rtl/clk_div_checker.sv
// Monitors a fixed-ratio divided clock sampled in the clk_i domain: measures period/high time,
// declares lock, flags ratio/duty errors and stuck clocks. CLK_DIV_CHECKER_SYNC_EN adds a 2-flop input synchronizer.
module clk_div_checker #(
    parameter int RATIO    = 2,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = $clog2(2*RATIO+1)
) (
    input logic              clk_i,
    input logic              rst_i,
    clk_div_checker_if.slave bus
);
    localparam int GW = $clog2(LOCK_CNT+1);
    localparam logic [CNT_W-1:0] RATIO_C = CNT_W'(RATIO);
    localparam logic [CNT_W-1:0] HALF_C  = CNT_W'(RATIO/2);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(2*RATIO);
    localparam logic [GW-1:0]    LOCK_C  = GW'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, STUCK} state_t;

    state_t           state_q;
    logic             div_s;
    logic             prev_q;
    logic [CNT_W-1:0] pcnt_q;
    logic [CNT_W-1:0] hcnt_q;
    logic [GW-1:0]    good_cnt_q;
    logic             edge_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_q;
    logic             lock_q;
    logic             err_q;
    logic             sticky_q;
    logic             stuck_q;
    logic [7:0]       err_cnt_q;

    logic             rise;
    logic             good;
    logic             timeout;
    logic [7:0]       err_cnt_nxt;

`ifdef CLK_DIV_CHECKER_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.div_clk_i};
        end
    end
    assign div_s = sync_q[1];
`else
    assign div_s = bus.div_clk_i;
`endif

    // A rise coinciding with the timeout is evaluated as a normal period.
    always_comb begin
        rise        = div_s & ~prev_q;
        good        = (pcnt_q == RATIO_C) && (hcnt_q == HALF_C);
        timeout     = (pcnt_q == MAX_C) && !rise;
        err_cnt_nxt = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            prev_q     <= 1'b0;
            pcnt_q     <= '0;
            hcnt_q     <= '0;
            good_cnt_q <= '0;
            edge_q     <= 1'b0;
            period_q   <= '0;
            high_q     <= '0;
            lock_q     <= 1'b0;
            err_q      <= 1'b0;
            sticky_q   <= 1'b0;
            stuck_q    <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            prev_q <= div_s;
            edge_q <= rise;
            err_q  <= 1'b0;

            if (rise) begin
                pcnt_q <= CNT_W'(1);
                hcnt_q <= CNT_W'(1);
            end else begin
                if (pcnt_q != MAX_C) pcnt_q <= pcnt_q + CNT_W'(1);
                if (div_s && hcnt_q != MAX_C) hcnt_q <= hcnt_q + CNT_W'(1);
            end

            if (rise && state_q != IDLE) begin
                period_q <= pcnt_q;
                high_q   <= hcnt_q;
            end

            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q    <= MEASURE;
                        good_cnt_q <= '0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        if (good) begin
                            if (good_cnt_q + GW'(1) == LOCK_C) begin
                                state_q <= LOCKED;
                                lock_q  <= 1'b1;
                            end
                            good_cnt_q <= good_cnt_q + GW'(1);
                        end else begin
                            good_cnt_q <= '0;
                            err_q      <= 1'b1;
                            sticky_q   <= 1'b1;
                            err_cnt_q  <= err_cnt_nxt;
                        end
                    end else if (timeout) begin
                        state_q   <= STUCK;
                        stuck_q   <= 1'b1;
                        sticky_q  <= 1'b1;
                        err_cnt_q <= err_cnt_nxt;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        if (!good) begin
                            state_q    <= MEASURE;
                            lock_q     <= 1'b0;
                            good_cnt_q <= '0;
                            err_q      <= 1'b1;
                            sticky_q   <= 1'b1;
                            err_cnt_q  <= err_cnt_nxt;
                        end
                    end else if (timeout) begin
                        state_q   <= STUCK;
                        lock_q    <= 1'b0;
                        stuck_q   <= 1'b1;
                        sticky_q  <= 1'b1;
                        err_cnt_q <= err_cnt_nxt;
                    end
                end
                STUCK: begin
                    if (rise) begin
                        state_q    <= MEASURE;
                        good_cnt_q <= '0;
                        stuck_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.edge_o       = edge_q;
    assign bus.period_o     = period_q;
    assign bus.high_o       = high_q;
    assign bus.lock_o       = lock_q;
    assign bus.err_o        = err_q;
    assign bus.err_sticky_o = sticky_q;
    assign bus.stuck_o      = stuck_q;
    assign bus.err_cnt_o    = err_cnt_q;
    assign bus.state_o      = state_q;
endmodule

// File: tb/tb_clk_div_checker.sv
// Bench for clk_div_checker: RATIO=4 instance checked every cycle against a period-level model,
// plus a RATIO=2 instance pinned by literal lock expectations.
module tb_clk_div_checker;
  localparam int R4 = 4;
  localparam int L4 = 4;
  localparam int W4 = $clog2(2*R4+1);
  localparam int R2 = 2;
  localparam int W2 = $clog2(2*R2+1);
`ifdef CLK_DIV_CHECKER_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_MEAS = 1;
  localparam int M_LOCK = 2;
  localparam int M_STUCK = 3;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst = 1'b1;
  always #5 clk_i = ~clk_i;

  clk_div_checker_if #(.CNT_W(W4)) bus4();
  clk_div_checker_if #(.CNT_W(W2)) bus2();

  clk_div_checker #(.RATIO(R4), .LOCK_CNT(L4)) u_dut4 (.clk_i(clk_i), .rst_i(rst), .bus(bus4));
  clk_div_checker #(.RATIO(R2), .LOCK_CNT(4))  u_dut2 (.clk_i(clk_i), .rst_i(rst), .bus(bus2));

  int n_checks = 0;
  int n_fail = 0;
  int err_pulses = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: periods measured as distance between rises
  int cyc = 0;
  int last_rise = 0;
  int ones = 0;
  bit m_prev = 0;
  bit s1 = 0, s2 = 0;
  int mode = M_IDLE;
  int streak = 0;
  int errs = 0;
  int e_period = 0, e_high = 0;
  bit e_edge = 0, e_err = 0, e_sticky = 0;

  task automatic model_step();
    bit d, rise, is_good;
    int el, hi;
    cyc++;
    if (rst) begin
      s1 = 0; s2 = 0; m_prev = 0; last_rise = cyc; ones = 0;
      mode = M_IDLE; streak = 0; errs = 0;
      e_period = 0; e_high = 0; e_edge = 0; e_err = 0; e_sticky = 0;
      return;
    end
    if (SYNC_LAT != 0) begin
      d = s2; s2 = s1; s1 = bus4.div_clk_i;
    end else begin
      d = bus4.div_clk_i;
    end
    rise = d && !m_prev;
    m_prev = d;
    el = cyc - last_rise;
    if (el > 2*R4) el = 2*R4;
    hi = (ones > 2*R4) ? 2*R4 : ones;
    is_good = (el == R4) && (hi == R4/2);
    e_edge = rise;
    e_err = 0;
    if (rise) begin
      exp_q.push_back(cyc);
      if (mode != M_IDLE) begin
        e_period = el;
        e_high = hi;
      end
      case (mode)
        M_IDLE: begin mode = M_MEAS; streak = 0; end
        M_MEAS: begin
          if (is_good) begin
            streak++;
            if (streak == L4) mode = M_LOCK;
          end else begin
            streak = 0; e_err = 1; errs++; e_sticky = 1;
          end
        end
        M_LOCK: if (!is_good) begin
          mode = M_MEAS; streak = 0; e_err = 1; errs++; e_sticky = 1;
        end
        default: begin mode = M_MEAS; streak = 0; end
      endcase
      last_rise = cyc;
      ones = 1;
    end else begin
      if ((mode == M_MEAS || mode == M_LOCK) && el == 2*R4) begin
        mode = M_STUCK; errs++; e_sticky = 1;
      end
      if (d) ones++;
    end
  endtask

  // compare process
  always @(posedge clk_i) begin
    #1;
    model_step();
    chk("edge", bus4.edge_o, e_edge);
    chk("period", bus4.period_o, e_period);
    chk("high", bus4.high_o, e_high);
    chk("lock", bus4.lock_o, (mode == M_LOCK));
    chk("err", bus4.err_o, e_err);
    chk("sticky", bus4.err_sticky_o, e_sticky);
    chk("stuck", bus4.stuck_o, (mode == M_STUCK));
    chk("err_cnt", bus4.err_cnt_o, (errs > 255) ? 255 : errs);
    if (bus4.edge_o === 1'b1) begin
      if (exp_q.size() == 0) chk("edge_unexpected", 1, 0);
      else chk("edge_cycle", cyc, exp_q.pop_front());
    end
    if (bus4.err_o === 1'b1) err_pulses++;
  end

  // driver tasks
  task automatic drive_period(input int p, input int h);
    for (int i = 0; i < p; i++) begin
      @(negedge clk_i);
      rst = 1'b0;
      bus4.div_clk_i = (i < h);
    end
  endtask

  task automatic drive_low(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      rst = 1'b0;
      bus4.div_clk_i = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      rst = 1'b1;
      bus4.div_clk_i = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, p, h;
    bus4.div_clk_i = 1'b0;
    bus2.div_clk_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_lock", bus4.lock_o, 0);
    chk("rst_err_cnt", bus4.err_cnt_o, 0);
    chk("rst_period", bus4.period_o, 0);
    chk("rst_stuck", bus4.stuck_o, 0);

    // divide-by-2 source on the RATIO=2 instance
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_i);
      rst = 1'b0;
      bus2.div_clk_i = k[0];
      @(posedge clk_i);
      #1;
      if (k == 8 + SYNC_LAT) chk("r2_prelock", bus2.lock_o, 0);
      if (k == 9 + SYNC_LAT) chk("r2_lock", bus2.lock_o, 1);
    end
    chk("r2_period", bus2.period_o, 2);
    chk("r2_high", bus2.high_o, 1);
    chk("r2_sticky", bus2.err_sticky_o, 0);
    chk("r2_err_cnt", bus2.err_cnt_o, 0);
    @(negedge clk_i);
    bus2.div_clk_i = 1'b0;

    // ratio error
    repeat (5) drive_period(4, 2);
    chk("lock_first", bus4.lock_o, 1);
    chk("period_good", bus4.period_o, 4);
    chk("high_good", bus4.high_o, 2);
    drive_period(5, 2);
    drive_period(4, 2);
    chk("ratio_lock_drop", bus4.lock_o, 0);
    chk("ratio_period", bus4.period_o, 5);
    chk("ratio_err_cnt", bus4.err_cnt_o, 1);
    chk("ratio_err_pulses", err_pulses, 1);
    repeat (4) drive_period(4, 2);
    chk("ratio_relock", bus4.lock_o, 1);

    // duty error
    drive_period(4, 1);
    drive_period(4, 2);
    chk("duty_lock", bus4.lock_o, 0);
    chk("duty_high", bus4.high_o, 1);
    chk("duty_period", bus4.period_o, 4);
    chk("duty_err_cnt", bus4.err_cnt_o, 2);
    chk("duty_sticky", bus4.err_sticky_o, 1);
    repeat (4) drive_period(4, 2);
    chk("duty_relock", bus4.lock_o, 1);

    // stuck clock
    drive_low(7 + SYNC_LAT);
    chk("stuck_flag", bus4.stuck_o, 1);
    chk("stuck_lock", bus4.lock_o, 0);
    chk("stuck_err_cnt", bus4.err_cnt_o, 3);
    repeat (5) drive_period(4, 2);
    chk("stuck_clear", bus4.stuck_o, 0);
    chk("stuck_relock", bus4.lock_o, 1);

    // reset while locked
    @(negedge clk_i);
    rst = 1'b1;
    bus4.div_clk_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("midrst_lock", bus4.lock_o, 0);
    chk("midrst_err_cnt", bus4.err_cnt_o, 0);
    chk("midrst_sticky", bus4.err_sticky_o, 0);
    chk("midrst_period", bus4.period_o, 0);
    chk("midrst_high", bus4.high_o, 0);

    // randomized periods, duty, stalls and resets
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 19);
      if (r < 10) begin
        drive_period(4, 2);
      end else if (r < 16) begin
        p = $urandom_range(2, 9);
        h = $urandom_range(1, p - 1);
        drive_period(p, h);
      end else if (r < 19) begin
        drive_low($urandom_range(3, 12));
      end else begin
        do_reset($urandom_range(1, 2));
      end
    end

    // saturation of the error counter
    do_reset(2);
    drive_period(4, 2);
    repeat (300) drive_period(5, 2);
    drive_period(4, 2);
    chk("sat_err_cnt", bus4.err_cnt_o, 255);
    repeat (3) drive_period(5, 2);
    drive_period(4, 2);
    chk("sat_hold", bus4.err_cnt_o, 255);
    drive_low(2);

    chk("edge_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_div_checker.md
Name: clk_div_checker

Overview:
- Downstream monitor for the fixed-ratio clock dividers in Counters_Dividers.
- Samples a divided clock as data in the source clk_i domain and measures its period and high time in clk_i cycles.
- Declares lock after LOCK_CNT consecutive correct periods.
- Flags ratio or duty errors and a stuck divided clock. Used as an in-design checker and as a bench reference.

Parameters:
- RATIO, 2, expected division ratio (≥2); expected period = RATIO clk_i cycles.
- LOCK_CNT, 4, consecutive good periods required to assert lock_o (≥1).
- CNT_W, $clog2(2*RATIO+1), period/high counter width (derived, do not override).

Ports:
- clk_i  input  1  source clock; also clocks the monitored divider.
- rst_i  input  1  synchronous, active-high reset.
- div_clk_i  input  1  divided clock under test, sampled on posedge clk_i.
- edge_o  output  1  one-cycle pulse on each detected rising edge of div_clk_i.
- period_o  output  CNT_W  last measured period in clk_i cycles.
- high_o  output  CNT_W  last measured high time in clk_i cycles.
- lock_o  output  1  ratio/duty verified for LOCK_CNT consecutive periods.
- err_o  output  1  one-cycle pulse on a bad period.
- err_sticky_o  output  1  set on any err_o or stuck event; cleared only by reset.
- stuck_o  output  1  high while no rising edge has been seen for 2*RATIO cycles.
- err_cnt_o  output  8  saturating count of bad periods plus stuck events.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous, active-high; all state is cleared on the first posedge clk_i with rst_i=1, including mid-operation.
- Reset values: every output and counter is 0, prev_q=0, FSM=IDLE.
- Edge detect: rise = div_clk_i & ~prev_q; prev_q <= div_clk_i.
  - edge_o is registered and follows the sampled rise by 1 cycle.
- Counters:
  - On rise: pcnt <= 1, hcnt <= 1.
  - Otherwise: pcnt increments, saturating at 2*RATIO; hcnt increments when div_clk_i=1, saturating.
- Good period: pcnt == RATIO and hcnt == RATIO/2 (floor), evaluated on the cycle of a rise.
  - On every rise outside IDLE: period_o <= pcnt, high_o <= hcnt.
- FSM states:
  - IDLE:
    - rise -> MEASURE, good_cnt=0. No compare on the first edge.
  - MEASURE:
    - Rise & good -> good_cnt++. When good_cnt reaches LOCK_CNT -> LOCKED, and lock_o=1 in the next cycle.
    - Rise & bad -> good_cnt=0, err_o pulse, err_cnt++, stay.
    - pcnt reaches 2*RATIO with no rise -> STUCK.
  - LOCKED:
    - Rise & good -> stay.
    - Rise & bad -> MEASURE, lock_o=0, good_cnt=0, err_o pulse.
    - Timeout -> STUCK, lock_o=0.
  - STUCK:
    - stuck_o=1; on entry, err_sticky_o=1 and err_cnt++ (once per entry).
    - Rise -> MEASURE, good_cnt=0, stuck_o=0. The period that ends on this rise is not compared.
- Simultaneous rise and timeout in the same cycle: the rise wins and is evaluated normally.
- err_cnt_o holds at 255.
- Output latency: lock_o, err_o, period_o and high_o update 1 cycle after the sampled rise.

Optional Feature:
- Macro: CLK_DIV_CHECKER_SYNC_EN.
- Defined: div_clk_i passes through a 2-flop synchronizer before edge detection. This adds 2 cycles to all output latencies and supports asynchronous div_clk_i sources.
- Undefined: div_clk_i is sampled directly. It must be synchronous to clk_i.

Test Plan:
- Lock with a divide-by-2 source (RATIO=2, LOCK_CNT=4): release reset while the divider toggles every clk_i -> first rise moves IDLE->MEASURE; lock_o=1 after the 5th rise; period_o=2, high_o=1; err_sticky_o=0.
- Ratio error (RATIO=4): drive period 4,4,4,4 (lock), then one period of 5 -> err_o pulses once, lock_o drops, period_o=5, err_cnt_o=1; four more good periods -> relock.
- Duty error (RATIO=4): period 4 with high=1 -> err_o pulses, high_o=1, lock_o stays 0 in MEASURE.
- Stuck clock (RATIO=4): while locked, hold div_clk_i=0 -> stuck_o=1 and lock_o=0 once 8 cycles have passed since the last rise; err_sticky_o=1, err_cnt_o=1; restart toggling -> stuck_o=0, relock after 4 good periods.
- Reset mid-lock: assert rst_i for 1 cycle while locked -> next cycle all outputs are 0 and FSM=IDLE; err_cnt_o=0.
- Saturation: inject 300 bad periods -> err_cnt_o=255 and holds.
